// File: rtl/fpu_pkg.sv
// Shared FPU datapath types: handshake FSM states and exception flag encodings.
// Used by the multiplier's Booth control and by the adder responder.
package fpu_pkg;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_OVF  = 2'b01;
    localparam logic [1:0] EXC_ZERO = 2'b10;

    typedef enum logic [1:0] {
        A_Idle,
        A_Calc,
        A_Ack
    } AdderState;

    typedef enum logic [1:0] {
        B_Idle,
        B_Calc,
        B_Wait,
        B_Done
    } BoothState;

endpackage

// File: rtl/adder_slice.sv
// One CHUNK-bit ripple slice; the responder reuses it once per cycle.
// Purely combinational.
module adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/adder_responder.sv
// Multi-cycle adder behind a 4-phase valid/ack handshake.
// Adds CHUNK bits per cycle, LSB first, through one shared slice.
module adder_responder
    import fpu_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int CHUNK  = 8,
    parameter int NCHUNK = WIDTH / CHUNK
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] Adder_datain1,
    input  logic [WIDTH-1:0] Adder_datain2,
    input  logic             Adder_valid,
    output logic [WIDTH-1:0] Adder_dataout,
    output logic             Adder_carryout,
    output logic [1:0]       Adder_Exc,
    output logic             Adder_ack
);

    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("adder_responder: WIDTH must be a multiple of CHUNK");
    end

    AdderState        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             cout_q, cout_d;
    logic [1:0]       exc_q, exc_d;
    logic             ack_q, ack_d;

    logic [CHUNK-1:0] s_a, s_b, s_sum;
    logic             s_cout;
    logic [WIDTH-1:0] res_full;
    logic             last;

    assign s_a  = a_q[cnt_q*CHUNK +: CHUNK];
    assign s_b  = b_q[cnt_q*CHUNK +: CHUNK];
    assign last = (cnt_q == CW'(NCHUNK - 1));

    adder_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout)
    );

    // Next-state, slice accumulation and output load on completion.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        dout_d   = dout_q;
        cout_d   = cout_q;
        exc_d    = exc_q;
        ack_d    = ack_q;
        res_full = res_q;
        res_full[cnt_q*CHUNK +: CHUNK] = s_sum;

        unique case (state_q)
            A_Idle: begin
                ack_d = 1'b0;
                if (Adder_valid) begin
                    a_d     = Adder_datain1;
                    b_d     = Adder_datain2;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    res_d   = '0;
                    state_d = A_Calc;
                end
            end
            A_Calc: begin
                if (!Adder_valid) begin
                    state_d = A_Idle;
                end else begin
                    res_d   = res_full;
                    carry_d = s_cout;
                    cnt_d   = cnt_q + 1'b1;
                    if (last) begin
                        dout_d = res_full;
                        cout_d = s_cout;
                        exc_d  = EXC_NONE;
                        if ((a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                            (res_full[WIDTH-1] != a_q[WIDTH-1]))
                            exc_d = exc_d | EXC_OVF;
                        if (res_full == '0)
                            exc_d = exc_d | EXC_ZERO;
                        ack_d   = 1'b1;
                        state_d = A_Ack;
                    end
                end
            end
            A_Ack: begin
                if (!Adder_valid) begin
                    ack_d   = 1'b0;
                    state_d = A_Idle;
                end
            end
            default: state_d = A_Idle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= A_Idle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            dout_q  <= '0;
            cout_q  <= 1'b0;
            exc_q   <= EXC_NONE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            cout_q  <= cout_d;
            exc_q   <= exc_d;
            ack_q   <= ack_d;
        end
    end

    assign Adder_dataout  = dout_q;
    assign Adder_carryout = cout_q;
    assign Adder_Exc      = exc_q;
    assign Adder_ack      = ack_q;

endmodule

// File: tb/tb_adder_responder.sv
// Scoreboard bench for adder_responder: expected results queued at drive
// time, popped by a monitor when ack rises.
module tb_adder_responder;

    localparam int W = 24;

    logic         CLK;
    logic         RSTn;
    logic [W-1:0] din1, din2;
    logic         valid;
    logic [W-1:0] dout;
    logic         cout;
    logic [1:0]   exc;
    logic         ack;

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        logic [1:0]   e;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic ack_prev = 1'b0;

    adder_responder dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .Adder_datain1  (din1),
        .Adder_datain2  (din2),
        .Adder_valid    (valid),
        .Adder_dataout  (dout),
        .Adder_carryout (cout),
        .Adder_Exc      (exc),
        .Adder_ack      (ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t        x;
        logic [W:0]  s;
        s   = {1'b0, a} + {1'b0, b};
        x.d = s[W-1:0];
        x.c = s[W];
        x.e[0] = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        x.e[1] = (s[W-1:0] == '0);
        return x;
    endfunction

    // Monitor: compare against the scoreboard on each rising ack.
    always @(negedge CLK) begin
        if (ack && !ack_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {31'd0, ack}, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("sum", {8'd0, dout}, {8'd0, x.d});
                chk("carry", {31'd0, cout}, {31'd0, x.c});
                chk("exc", {30'd0, exc}, {30'd0, x.e});
            end
        end
        ack_prev = ack;
    end

    task automatic req(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold);
        exp_t x;
        int   n;
        x = model(a, b);
        sb.push_back(x);
        @(negedge CLK);
        din1  = a;
        din2  = b;
        valid = 1'b1;
        @(posedge CLK);
        #1;
        n = 0;
        while (!ack && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("latency", n, 32'd3);
        repeat (hold) begin
            @(posedge CLK);
            #1;
            chk("ack_hold", {31'd0, ack}, 32'd1);
            chk("hold_data", {8'd0, dout}, {8'd0, x.d});
        end
        @(negedge CLK);
        valid = 1'b0;
        @(posedge CLK);
        #1;
        chk("ack_drop", {31'd0, ack}, 32'd0);
        chk("drop_data", {8'd0, dout}, {8'd0, x.d});
    endtask

    initial begin
        RSTn  = 1'b0;
        valid = 1'b0;
        din1  = '0;
        din2  = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_dout", {8'd0, dout}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_exc", {30'd0, exc}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;

        req(24'h000001, 24'h000001, 2);
        req(24'h7FFFFF, 24'h000001, 0);
        req(24'hFFFFFF, 24'h000001, 1);
        req(24'h800000, 24'h800000, 0);
        req(24'h0000FF, 24'h000001, 0);
        req(24'h00FFFF, 24'h000001, 0);

        // Reset on the second compute edge.
        @(negedge CLK);
        din1  = 24'h123456;
        din2  = 24'h111111;
        valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        RSTn  = 1'b0;
        valid = 1'b0;
        @(posedge CLK);
        #1;
        chk("mid_rst_dout", {8'd0, dout}, 32'd0);
        chk("mid_rst_cout", {31'd0, cout}, 32'd0);
        chk("mid_rst_exc", {30'd0, exc}, 32'd0);
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (4) begin
            @(posedge CLK);
            #1;
            chk("post_rst_ack", {31'd0, ack}, 32'd0);
        end
        req(24'h123456, 24'h111111, 0);

        // Abort: drop valid mid-compute.
        @(negedge CLK);
        din1  = 24'h000005;
        din2  = 24'h000005;
        valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        valid = 1'b0;
        repeat (5) begin
            @(posedge CLK);
            #1;
            chk("abort_ack", {31'd0, ack}, 32'd0);
            chk("abort_dout", {8'd0, dout}, 32'h234567);
        end

        // Back-to-back Booth-style requests.
        req(24'h000003, 24'hFFFFFD, 0);
        req(24'h000010, 24'hFFFFF0, 0);

        repeat (3) @(posedge CLK);
        #1;
        chk("sb_left", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
